bram_port_arb: RTL and testbench

- Two-requester arbiter sharing the single port of an 11-word, 32-bit, byte-write BRAM (tap or data RAM of the FIR block).
- Requester 0 is the AXI-Lite config path (tap coefficient load and readback). Requester 1 is the FIR engine (coefficient and data fetch).
- Handles grant selection, byte-address range checking, and read-return tagging.
- Respects the BRAM timing: read address is registered and read data is gated by the current-cycle EN.

---
 rtl/bram_arb_pkg.sv | 12 +
 rtl/bram_arb_pick.sv | 22 ++
 rtl/bram_port_arb.sv | 80 ++++++++
 tb/tb_bram_port_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared constants, types and address check for the BRAM port arbiter
package bram_arb_pkg;
  localparam int DEPTH = 11;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int WE_W = 4;
  typedef enum logic {S_IDLE, S_LOCK1} arb_state_t;
  typedef logic req_id_t;
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 2) < ADDR_W'(DEPTH));
  endfunction
endpackage

// File: rtl/bram_arb_pick.sv
// bram_arb_pick: 2-way one-hot grant picker; ARB_RR_EN selects round-robin, else r0 has fixed priority
module bram_arb_pick
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt
);
`ifdef ARB_RR_EN
  req_id_t last_gnt;
  always_ff @(posedge clk)
    if (rst) last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[1];
  always_comb gnt = lock ? {req[1], 1'b0} : (&req) ? (last_gnt ? 2'b01 : 2'b10) : req;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  always_comb gnt = lock ? {req[1], 1'b0} : {req[1] & ~req[0], req[0]};
`endif
endmodule

// File: rtl/bram_port_arb.sv
// bram_port_arb: shares one byte-write BRAM port between config (r0) and FIR engine (r1); ARB_RR_EN in bram_arb_pick
module bram_port_arb
  import bram_arb_pkg::*;
(
  input  logic              axis_clk,
  input  logic              axis_rst,
  input  logic              r0_req,
  input  logic [WE_W-1:0]   r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic [WE_W-1:0]   r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  input  logic              r1_lock,
  output logic              bram_EN,
  output logic [WE_W-1:0]   bram_WE,
  output logic [ADDR_W-1:0] bram_A,
  output logic [DATA_W-1:0] bram_Di,
  input  logic [DATA_W-1:0] bram_Do
);
  arb_state_t state, state_nx;
  logic [1:0] gnt;
  logic any, ok, rd_v, err_v;
  req_id_t id, rd_id, err_id;
  logic [ADDR_W-1:0] addr;
  logic [WE_W-1:0] we;
  logic [DATA_W-1:0] wdata;
  bram_arb_pick u_pick (
    .clk (axis_clk),
    .rst (axis_rst),
    .req ({r1_req, r0_req} & {2{~axis_rst}}),
    .lock(state == S_LOCK1 && r1_lock),
    .gnt (gnt)
  );
  // Pending read keeps EN high in T+1 because the BRAM gates its output with the current EN
  always_comb begin
    any = |gnt;
    id = gnt[1];
    addr = id ? r1_addr : r0_addr;
    we = id ? r1_we : r0_we;
    wdata = id ? r1_wdata : r0_wdata;
    ok = any && addr_ok(addr);
    state_nx = ((gnt[1] || state == S_LOCK1) && r1_lock) ? S_LOCK1 : S_IDLE;
    r0_gnt = gnt[0];
    r1_gnt = gnt[1];
    bram_EN = ok || (rd_v && !axis_rst);
    bram_WE = ok ? we : '0;
    bram_A = any ? addr : '0;
    bram_Di = any ? wdata : '0;
    r0_rvalid = rd_v && !rd_id && !axis_rst;
    r1_rvalid = rd_v && rd_id && !axis_rst;
    r0_rdata = r0_rvalid ? bram_Do : '0;
    r1_rdata = r1_rvalid ? bram_Do : '0;
    r0_err = err_v && !err_id && !axis_rst;
    r1_err = err_v && err_id && !axis_rst;
  end
  always_ff @(posedge axis_clk)
    if (axis_rst) begin
      state <= S_IDLE;
      rd_v <= 1'b0;
      rd_id <= 1'b0;
      err_v <= 1'b0;
      err_id <= 1'b0;
    end else begin
      state <= state_nx;
      rd_v <= ok && we == '0;
      rd_id <= id;
      err_v <= any && !ok;
      err_id <= id;
    end
endmodule

// File: tb/tb_bram_port_arb.sv
// tb_bram_port_arb: directed self-checking bench with a behavioural 11-word byte-write BRAM
module tb_bram_port_arb;
  import bram_arb_pkg::*;
  logic axis_clk = 1'b0, axis_rst = 1'b1;
  logic r0_req = 1'b0, r1_req = 1'b0, r1_lock = 1'b0;
  logic [3:0] r0_we = '0, r1_we = '0;
  logic [11:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, bram_EN;
  logic [31:0] r0_rdata, r1_rdata, bram_Di, bram_Do, q;
  logic [3:0] bram_WE;
  logic [11:0] bram_A;
  logic [31:0] mem [0:10];
  int checks = 0, errors = 0;
  int w, l;

  bram_port_arb dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .r1_lock(r1_lock),
    .bram_EN(bram_EN), .bram_WE(bram_WE), .bram_A(bram_A), .bram_Di(bram_Di), .bram_Do(bram_Do)
  );

  always #5 axis_clk = ~axis_clk;

  wire [3:0] idx = bram_A[5:2];
  always @(posedge axis_clk)
    if (axis_rst) begin
      for (int i = 0; i < 11; i++) mem[i] <= 32'h5A00_0000 + i;
      q <= '0;
    end else if (bram_EN && idx < 4'd11) begin
      for (int b = 0; b < 4; b++) if (bram_WE[b]) mem[idx][8*b +: 8] <= bram_Di[8*b +: 8];
      q <= mem[idx];
    end
  assign bram_Do = bram_EN ? q : '0;

  wire [1:0] gnt_v = {r1_gnt, r0_gnt};
  wire [1:0] rv_v = {r1_rvalid, r0_rvalid};
  wire [1:0] er_v = {r1_err, r0_err};

  function automatic logic [31:0] rdata_of(input int id);
    return id != 0 ? r1_rdata : r0_rdata;
  endfunction

  function automatic logic [31:0] expw(input int k);
    return k == 0 ? 32'hA0A0_A0A0 : k == 1 ? 32'hB1B1_B1B1 : k == 2 ? 32'hDEAD_BEEF :
           k == 3 ? 32'h1122_AB44 : 32'h5A00_0000 + k;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req_set(input int id, input logic r, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
    if (id == 0) begin r0_req = r; r0_we = we; r0_addr = a; r0_wdata = d; end
    else begin r1_req = r; r1_we = we; r1_addr = a; r1_wdata = d; end
  endtask

  task automatic xfer(input int id, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input logic bad);
    @(negedge axis_clk);
    req_set(id, 1'b1, we, a, d);
    #1;
    chk("gnt", gnt_v[id], 1);
    chk("en_t", bram_EN, !bad);
    chk("we_t", bram_WE, bad ? 4'h0 : we);
    chk("addr_t", bram_A, a);
    chk("di_t", bram_Di, d);
    @(negedge axis_clk);
    req_set(id, 1'b0, '0, '0, '0);
    #1;
    chk("err_t1", er_v[id], bad);
    if (we == 4'h0 && !bad) begin
      chk("rvalid_t1", rv_v[id], 1);
      chk("rdata_t1", rdata_of(id), exp);
      chk("en_t1", bram_EN, 1);
    end else
      chk("no_rvalid_t1", rv_v[id], 0);
  endtask

  initial begin
    @(negedge axis_clk);
    req_set(0, 1'b1, 4'hF, 12'h008, 32'h1234_5678);
    @(negedge axis_clk);
    #1;
    chk("rst_gnt0", r0_gnt, 0);
    chk("rst_gnt1", r1_gnt, 0);
    chk("rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
    chk("rst_err", {r1_err, r0_err}, 0);
    chk("rst_rdata0", r0_rdata, 0);
    chk("rst_rdata1", r1_rdata, 0);
    chk("rst_en", bram_EN, 0);
    chk("rst_we", bram_WE, 0);
    chk("rst_a", bram_A, 0);
    chk("rst_di", bram_Di, 0);
    chk("rst_state", 32'(dut.state), 32'(S_IDLE));
    @(negedge axis_clk);
    req_set(0, 1'b0, '0, '0, '0);
    axis_rst = 1'b0;

    xfer(0, 4'hF, 12'h008, 32'hDEAD_BEEF, '0, 1'b0);
    xfer(0, 4'h0, 12'h008, '0, 32'hDEAD_BEEF, 1'b0);
    @(negedge axis_clk);
    #1;
    chk("idle_en", bram_EN, 0);
    chk("idle_we", bram_WE, 0);

    xfer(0, 4'hF, 12'h00C, 32'h1122_3344, '0, 1'b0);
    xfer(0, 4'b0010, 12'h00C, 32'h0000_AB00, '0, 1'b0);
    xfer(0, 4'h0, 12'h00C, '0, 32'h1122_AB44, 1'b0);
    xfer(1, 4'hF, 12'h004, 32'hB1B1_B1B1, '0, 1'b0);
    xfer(0, 4'hF, 12'h000, 32'hA0A0_A0A0, '0, 1'b0);

`ifdef ARB_RR_EN
    w = 1;
`else
    w = 0;
`endif
    l = 1 - w;
    @(negedge axis_clk);
    req_set(0, 1'b1, 4'h0, 12'h000, '0);
    req_set(1, 1'b1, 4'h0, 12'h004, '0);
    #1;
    chk("sim_gnt_first", gnt_v, w != 0 ? 2'b10 : 2'b01);
    @(negedge axis_clk);
    req_set(w, 1'b0, '0, '0, '0);
    #1;
    chk("sim_gnt_second", gnt_v, l != 0 ? 2'b10 : 2'b01);
    chk("sim_rvalid_first", rv_v, w != 0 ? 2'b10 : 2'b01);
    chk("sim_rdata_first", rdata_of(w), expw(w));
    @(negedge axis_clk);
    req_set(l, 1'b0, '0, '0, '0);
    #1;
    chk("sim_rvalid_second", rv_v, l != 0 ? 2'b10 : 2'b01);
    chk("sim_rdata_second", rdata_of(l), expw(l));

    for (int k = 0; k < 11; k++) begin
      @(negedge axis_clk);
      req_set(1, 1'b1, 4'h0, 12'(4 * k), '0);
      r1_lock = 1'b1;
      if (k == 1) req_set(0, 1'b1, 4'h0, 12'h010, '0);
      #1;
      chk("lock_gnt0", r0_gnt, 0);
      chk("lock_gnt1", r1_gnt, 1);
      if (k > 0) begin
        chk("lock_rvalid1", r1_rvalid, 1);
        chk("lock_rdata1", r1_rdata, expw(k - 1));
      end
    end
    @(negedge axis_clk);
    r1_lock = 1'b0;
    req_set(1, 1'b0, '0, '0, '0);
    #1;
    chk("unlock_gnt0", r0_gnt, 1);
    chk("unlock_rvalid1", r1_rvalid, 1);
    chk("unlock_rdata1", r1_rdata, expw(10));
    @(negedge axis_clk);
    req_set(0, 1'b0, '0, '0, '0);
    #1;
    chk("unlock_rvalid0", r0_rvalid, 1);
    chk("unlock_rdata0", r0_rdata, expw(4));
    chk("unlock_state", 32'(dut.state), 32'(S_IDLE));

    xfer(0, 4'hF, 12'h02C, 32'hFFFF_FFFF, '0, 1'b1);
    xfer(1, 4'hF, 12'h006, 32'hFFFF_FFFF, '0, 1'b1);
    xfer(0, 4'h0, 12'h006, '0, '0, 1'b1);
    xfer(0, 4'h0, 12'h004, '0, 32'hB1B1_B1B1, 1'b0);
    xfer(1, 4'h0, 12'h028, '0, 32'h5A00_000A, 1'b0);

    @(negedge axis_clk);
    req_set(0, 1'b1, 4'h0, 12'h000, '0);
    #1;
    chk("mid_rst_gnt", r0_gnt, 1);
    @(negedge axis_clk);
    req_set(0, 1'b0, '0, '0, '0);
    axis_rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", r0_rvalid, 0);
    chk("mid_rst_rdata", r0_rdata, 0);
    chk("mid_rst_en", bram_EN, 0);
    @(negedge axis_clk);
    axis_rst = 1'b0;
    #1;
    chk("post_rst_rvalid", {r1_rvalid, r0_rvalid}, 0);
    chk("post_rst_err", {r1_err, r0_err}, 0);
    chk("post_rst_en", bram_EN, 0);
    chk("post_rst_state", 32'(dut.state), 32'(S_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
